atomrvcore_mem_stage: RTL and testbench
=======================================

Name: atomrvcore_mem_stage

Overview:
Memory-access stage directly downstream of the execute/ALU stage. It consumes that stage's registered result, address, store data, destination register and read/write enables. Loads and stores go out on a req/gnt/rvalid data-memory bus. Non-memory instructions pass through, and one write-back bundle per accepted instruction goes to the register-file write stage. It stalls the upstream pipeline while a memory transaction is outstanding.

Parameters:
DATAWIDTH, 32, data/address width
REG_ADRESS_WIDTH, 5, register index width
TIMEOUT_CYCLES, 16, max cycles waited in REQ or WAIT_RSP before abort (>=2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  upstream instruction present (0 = bubble)
result_i  in  DATAWIDTH  ALU result (write-back value for non-loads)
address_i  in  DATAWIDTH  memory byte address
dr_en_i  in  1  load
dwr_en_i  in  1  store
r2_i  in  DATAWIDTH  store data
rd_i  in  REG_ADRESS_WIDTH  destination register
rwr_en_i  in  1  register write enable
stall_o  out  1  upstream must hold its outputs
dmem_req_o  out  1  memory request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  DATAWIDTH  word-aligned address
dmem_wdata_o  out  DATAWIDTH  store data
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  DATAWIDTH  load data
wb_valid_o  out  1  one-cycle pulse: write-back bundle valid
wb_we_o  out  1  register write enable
wb_rd_o  out  REG_ADRESS_WIDTH  destination register
wb_data_o  out  DATAWIDTH  write-back value
err_o  out  1  one-cycle pulse: misaligned access or timeout

Behaviour:
- FSM states: IDLE, REQ, WAIT_RSP. stall_o = (state != IDLE), combinational.
- Acceptance: an instruction is accepted when valid_i && !stall_o. Inputs are sampled only at acceptance.
- Non-memory accept (dr_en_i=dwr_en_i=0): 1-cycle latency. Next cycle wb_valid_o=1, wb_we_o=rwr_en_i, wb_rd_o=rd_i, wb_data_o=result_i. State stays IDLE.
- Memory accept with address_i[1:0]!=0: no bus request. Next cycle err_o=1, wb_valid_o=1, wb_we_o=0. State stays IDLE.
- Aligned memory accept: latch address, r2_i, rd_i, rwr_en_i and load/store into holding registers. Go to REQ; the counter is cleared.
- dr_en_i && dwr_en_i both set: treated as a load.
- REQ: dmem_req_o=1. dmem_we_o, dmem_addr_o and dmem_wdata_o are held stable until gnt.
  - On gnt for a store: go IDLE; next cycle wb_valid_o=1, wb_we_o=0.
  - On gnt for a load: go WAIT_RSP.
  - gnt && rvalid in the same cycle for a load: completes as in WAIT_RSP, going directly to IDLE.
- WAIT_RSP: dmem_req_o=0. On rvalid: wb_valid_o=1, wb_we_o=held rwr_en, wb_rd_o=held rd, wb_data_o=dmem_rdata_i, all registered. Go IDLE.
- dmem_rvalid_i in IDLE is ignored.
- Timeout: the counter increments each cycle in REQ/WAIT_RSP. When it reaches TIMEOUT_CYCLES-1 without completion: go IDLE, dmem_req_o drops, err_o=1 and wb_valid_o=1 with wb_we_o=0 next cycle. A late rvalid is ignored.
- Minimum memory-op latency: accept -> REQ (cycle 1) -> gnt -> write-back visible at cycle 2 (store, or load with same-cycle rvalid).
- dmem_* outputs are 0 when dmem_req_o=0.
- Reset (rst_i=1, any state, including mid-transaction): state IDLE, counter 0, holding registers 0. Outputs reset to 0: dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, err_o. stall_o=0. Any outstanding transaction is abandoned.

Decomposition:
- Shared package atomrvcore_pkg holds:
  - mem_state_e enum (IDLE, REQ, WAIT_RSP)
  - DATAWIDTH and REG_ADRESS_WIDTH defaults
  - a typedef wb_bundle_t struct {we, rd, data}
- One sub-module is natural: atomrvcore_mem_timeout. It is a clear/enable counter with a terminal-count output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- ALU op: valid_i=1, rwr_en_i=1, rd_i=5, result_i=0x1234 -> next cycle wb_valid_o=1, wb_we_o=1, wb_rd_o=5, wb_data_o=0x1234; stall_o stays 0.
- Store to address 0x100, r2_i=0xDEADBEEF, gnt after 2 cycles -> dmem_req_o=1, dmem_we_o=1, addr/wdata stable for 3 cycles; stall_o=1 throughout; one wb_valid_o pulse with wb_we_o=0.
- Load from 0x200, rd_i=7, gnt at cycle 1, rvalid 3 cycles later with 0xCAFEF00D -> wb_data_o=0xCAFEF00D, wb_rd_o=7, wb_we_o=1; next valid_i instruction held upstream until stall_o=0.
- Load to 0x203 -> no dmem_req_o, err_o pulse, wb_valid_o=1, wb_we_o=0 one cycle after accept.
- Load, gnt given, rvalid never arrives -> after TIMEOUT_CYCLES: err_o pulse, state IDLE, stall_o=0; a later spurious rvalid produces no wb_valid_o.
- rst_i asserted in WAIT_RSP -> next cycle all outputs 0, stall_o=0; the following load behaves normally.

Source files
------------

// File: rtl/atomrvcore_pkg.sv
// Shared types and defaults for the atomrvcore memory stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package atomrvcore_pkg;

  localparam int DEF_DATAWIDTH        = 32;
  localparam int DEF_REG_ADRESS_WIDTH = 5;

  // Memory-stage controller states
  typedef enum logic [1:0] {
    MEM_IDLE     = 2'd0,
    MEM_REQ      = 2'd1,
    MEM_WAIT_RSP = 2'd2
  } mem_state_e;

  // Write-back bundle handed to the register-file write stage
  typedef struct packed {
    logic                            we;
    logic [DEF_REG_ADRESS_WIDTH-1:0] rd;
    logic [DEF_DATAWIDTH-1:0]        data;
  } wb_bundle_t;

endpackage

// File: rtl/atomrvcore_mem_timeout.sv
// Clear/enable cycle counter with a terminal-count flag for bus-transaction timeouts.
// Latency: tc is combinational from the count; the count updates on the rising edge.
// Backpressure: none; the count saturates at TIMEOUT_CYCLES-1 until cleared.
module atomrvcore_mem_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  assign tc = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on the bus; clear takes priority, hold at terminal count
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/atomrvcore_mem_stage.sv
// Memory-access stage: issues loads/stores on a req/gnt/rvalid bus, passes ALU results to write-back.
// Latency: 1 cycle for non-memory ops and misaligned errors; >=2 cycles for memory ops.
// Backpressure: stall_o holds upstream while a bus transaction is outstanding; TIMEOUT_CYCLES bounds it.
module atomrvcore_mem_stage import atomrvcore_pkg::*; #(
  parameter int DATAWIDTH        = DEF_DATAWIDTH,
  parameter int REG_ADRESS_WIDTH = DEF_REG_ADRESS_WIDTH,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  input  logic [DATAWIDTH-1:0]        result_i,
  input  logic [DATAWIDTH-1:0]        address_i,
  input  logic                        dr_en_i,
  input  logic                        dwr_en_i,
  input  logic [DATAWIDTH-1:0]        r2_i,
  input  logic [REG_ADRESS_WIDTH-1:0] rd_i,
  input  logic                        rwr_en_i,
  output logic                        stall_o,
  output logic                        dmem_req_o,
  output logic                        dmem_we_o,
  output logic [DATAWIDTH-1:0]        dmem_addr_o,
  output logic [DATAWIDTH-1:0]        dmem_wdata_o,
  input  logic                        dmem_gnt_i,
  input  logic                        dmem_rvalid_i,
  input  logic [DATAWIDTH-1:0]        dmem_rdata_i,
  output logic                        wb_valid_o,
  output logic                        wb_we_o,
  output logic [REG_ADRESS_WIDTH-1:0] wb_rd_o,
  output logic [DATAWIDTH-1:0]        wb_data_o,
  output logic                        err_o
);

  localparam logic [1:0] ST_IDLE     = MEM_IDLE;
  localparam logic [1:0] ST_REQ      = MEM_REQ;
  localparam logic [1:0] ST_WAIT_RSP = MEM_WAIT_RSP;

  logic [1:0]                  state_q, state_d;
  logic [DATAWIDTH-1:0]        addr_q, wdata_q;
  logic [REG_ADRESS_WIDTH-1:0] rd_q;
  logic                        rwr_q, load_q;
  wb_bundle_t                  wb_q;
  logic                        wb_valid_q, err_q;

  logic accept, is_mem, misaligned, start_mem;
  logic tc, done_ok, abort;

  assign stall_o    = (state_q != ST_IDLE);
  assign accept     = valid_i && !stall_o;
  assign is_mem     = dr_en_i || dwr_en_i;
  assign misaligned = (address_i[1:0] != 2'b00);
  assign start_mem  = accept && is_mem && !misaligned;

  // Bus signals are only driven while the request is pending; zero otherwise
  assign dmem_req_o   = (state_q == ST_REQ);
  assign dmem_we_o    = dmem_req_o && !load_q;
  assign dmem_addr_o  = dmem_req_o ? {addr_q[DATAWIDTH-1:2], 2'b00} : '0;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : '0;

  assign wb_valid_o = wb_valid_q;
  assign wb_we_o    = wb_q.we;
  assign wb_rd_o    = wb_q.rd;
  assign wb_data_o  = wb_q.data;
  assign err_o      = err_q;

  atomrvcore_mem_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (!stall_o),
    .en    (stall_o),
    .tc    (tc)
  );

  // Next-state: completion beats the timeout when both land in the same cycle
  always_comb begin
    state_d = state_q;
    done_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_mem) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (dmem_gnt_i && (!load_q || dmem_rvalid_i)) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
        end else if (dmem_gnt_i && !tc) begin
          state_d = ST_WAIT_RSP;
        end else if (tc) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
        end else if (tc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    abort = stall_o && !done_ok && tc;
  end

  // State register and holding registers captured when a bus access is launched
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      rwr_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_mem) begin
        addr_q  <= address_i;
        wdata_q <= r2_i;
        rd_q    <= rd_i;
        rwr_q   <= rwr_en_i;
        load_q  <= dr_en_i;
      end
    end
  end

  // Registered write-back bundle; valid and err are single-cycle pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (accept && !is_mem) begin
        wb_valid_q <= 1'b1;
        wb_q.we    <= rwr_en_i;
        wb_q.rd    <= rd_i;
        wb_q.data  <= result_i;
      end else if (accept && misaligned) begin
        wb_valid_q <= 1'b1;
        err_q      <= 1'b1;
        wb_q.we    <= 1'b0;
        wb_q.rd    <= rd_i;
        wb_q.data  <= '0;
      end else if (done_ok) begin
        wb_valid_q <= 1'b1;
        wb_q.we    <= load_q && rwr_q;
        wb_q.rd    <= rd_q;
        wb_q.data  <= load_q ? dmem_rdata_i : '0;
      end else if (abort) begin
        wb_valid_q <= 1'b1;
        err_q      <= 1'b1;
        wb_q.we    <= 1'b0;
        wb_q.rd    <= rd_q;
        wb_q.data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_atomrvcore_mem_stage.sv
// Bench for the memory stage: directed scenarios plus randomized transactions.
// Latency: expected write-back timing is derived per transaction from grant/response delays.
// Backpressure: a follow-on instruction is held on valid_i to confirm it waits for stall_o low.
module tb_atomrvcore_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int T  = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i;
  logic [DW-1:0] result_i, address_i, r2_i;
  logic          dr_en_i, dwr_en_i;
  logic [RW-1:0] rd_i;
  logic          rwr_en_i;
  logic          stall_o, dmem_req_o, dmem_we_o;
  logic [DW-1:0] dmem_addr_o, dmem_wdata_o;
  logic          dmem_gnt_i, dmem_rvalid_i;
  logic [DW-1:0] dmem_rdata_i;
  logic          wb_valid_o, wb_we_o;
  logic [RW-1:0] wb_rd_o;
  logic [DW-1:0] wb_data_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  atomrvcore_mem_stage #(
    .DATAWIDTH        (DW),
    .REG_ADRESS_WIDTH (RW),
    .TIMEOUT_CYCLES   (T)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .result_i      (result_i),
    .address_i     (address_i),
    .dr_en_i       (dr_en_i),
    .dwr_en_i      (dwr_en_i),
    .r2_i          (r2_i),
    .rd_i          (rd_i),
    .rwr_en_i      (rwr_en_i),
    .stall_o       (stall_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_we_o       (wb_we_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .err_o         (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_i       = 1'b0;
    result_i      = '0;
    address_i     = '0;
    r2_i          = '0;
    dr_en_i       = 1'b0;
    dwr_en_i      = 1'b0;
    rd_i          = '0;
    rwr_en_i      = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  stall_o, 0);
    chk({tag, "_req"},    dmem_req_o, 0);
    chk({tag, "_dwe"},    dmem_we_o, 0);
    chk({tag, "_daddr"},  dmem_addr_o, 0);
    chk({tag, "_dwdata"}, dmem_wdata_o, 0);
    chk({tag, "_wbv"},    wb_valid_o, 0);
    chk({tag, "_wbwe"},   wb_we_o, 0);
    chk({tag, "_wbrd"},   wb_rd_o, 0);
    chk({tag, "_wbdata"}, wb_data_o, 0);
    chk({tag, "_err"},    err_o, 0);
  endtask

  // Non-memory instruction: write-back one cycle after acceptance, pulse then clears
  task automatic alu_op(input logic [RW-1:0] rd, input logic [DW-1:0] res, input logic we);
    valid_i = 1'b1; dr_en_i = 1'b0; dwr_en_i = 1'b0;
    rd_i = rd; result_i = res; rwr_en_i = we;
    address_i = $urandom(); r2_i = $urandom();
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("alu_wbv", wb_valid_o, 1);
    chk("alu_we", wb_we_o, we);
    chk("alu_rd", wb_rd_o, rd);
    chk("alu_data", wb_data_o, res);
    chk("alu_stall", stall_o, 0);
    chk("alu_req", dmem_req_o, 0);
    chk("alu_err", err_o, 0);
    @(negedge clk_i);
    chk("alu_pulse", wb_valid_o, 0);
  endtask

  // Misaligned access: no bus request, error write-back one cycle later
  task automatic misaligned_op(input logic dr, input logic dwr, input logic [DW-1:0] addr);
    valid_i = 1'b1; dr_en_i = dr; dwr_en_i = dwr; address_i = addr;
    r2_i = $urandom(); rd_i = RW'($urandom()); rwr_en_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; dr_en_i = 1'b0; dwr_en_i = 1'b0;
    chk("mis_req", dmem_req_o, 0);
    chk("mis_stall", stall_o, 0);
    chk("mis_wbv", wb_valid_o, 1);
    chk("mis_we", wb_we_o, 0);
    chk("mis_err", err_o, 1);
    @(negedge clk_i);
    chk("mis_wbv_pulse", wb_valid_o, 0);
    chk("mis_err_pulse", err_o, 0);
  endtask

  // Aligned memory access. g = cycles in REQ before gnt, r = cycles from gnt to rvalid (loads).
  // Reference timing: the access finishes on wait-cycle index g (store) or g+r (load) if that
  // index is at most T-1; otherwise it is aborted at index T-1. Write-back follows one cycle later.
  task automatic mem_op(input logic dr, input logic dwr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [RW-1:0] rd, input logic rwr,
                        input int g, input int r, input logic [DW-1:0] rdata, input bit hold);
    bit            load;
    int            comp, cend, lastk, req_last;
    bit            ok;
    logic [RW-1:0] h_rd;
    logic [DW-1:0] h_res;
    logic          h_we;
    load     = dr;
    comp     = load ? g + r : g;
    ok       = (comp <= T - 1);
    cend     = ok ? comp : T - 1;
    req_last = ((g < T - 1) ? g : T - 1) + 1;
    lastk    = (cend + 3 > g + r + 2) ? cend + 3 : g + r + 2;
    h_rd = RW'($urandom()); h_res = $urandom(); h_we = 1'($urandom());

    valid_i = 1'b1; dr_en_i = dr; dwr_en_i = dwr; address_i = addr;
    r2_i = wdata; rd_i = rd; rwr_en_i = rwr; result_i = $urandom();
    @(negedge clk_i);
    if (hold) begin
      // follow-on ALU op sits on the bus with scrambled operand fields
      dr_en_i = 1'b0; dwr_en_i = 1'b0; rd_i = h_rd; result_i = h_res; rwr_en_i = h_we;
      address_i = $urandom(); r2_i = $urandom();
    end else begin
      idle_inputs();
    end

    for (int k = 1; k <= lastk; k++) begin
      chk("mem_stall", stall_o, (k <= cend + 1));
      chk("mem_req", dmem_req_o, (k <= req_last));
      if (k <= req_last) begin
        chk("mem_dwe", dmem_we_o, !load);
        chk("mem_daddr", dmem_addr_o, addr);
        chk("mem_dwdata", dmem_wdata_o, wdata);
      end else begin
        chk("mem_daddr_zero", dmem_addr_o, 0);
      end
      chk("mem_wbv", wb_valid_o, (k == cend + 2) || (hold && k == cend + 3));
      if (k == cend + 2) begin
        chk("mem_err", err_o, !ok);
        chk("mem_wbwe", wb_we_o, ok && load && rwr);
        if (ok && load) begin
          chk("mem_wbdata", wb_data_o, rdata);
          chk("mem_wbrd", wb_rd_o, rd);
        end
      end else begin
        chk("mem_err_quiet", err_o, 0);
      end
      if (hold && k == cend + 3) begin
        chk("hold_we", wb_we_o, h_we);
        chk("hold_rd", wb_rd_o, h_rd);
        chk("hold_data", wb_data_o, h_res);
      end
      dmem_gnt_i    = (k == g + 1);
      dmem_rvalid_i = load && (k == g + r + 1);
      dmem_rdata_i  = dmem_rvalid_i ? rdata : $urandom();
      if (hold && k == cend + 3) valid_i = 1'b0;
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  initial begin
    int kind, g, r;
    logic [DW-1:0] a;
    logic ld, st;

    idle_inputs();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk_all_zero("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // ALU pass-through
    alu_op(5'd5, 32'h1234, 1'b1);
    alu_op(5'd31, 32'hFFFF_0000, 1'b0);

    // Store, gnt after 2 cycles, with a follow-on instruction held upstream
    mem_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3, 1'b1, 2, 0, 32'h0, 1'b1);
    // Load, gnt at cycle 1, rvalid 3 cycles later, follow-on held
    mem_op(1'b1, 1'b0, 32'h200, 32'h0, 5'd7, 1'b1, 0, 3, 32'hCAFEF00D, 1'b1);
    // Minimum latency: load with same-cycle gnt+rvalid; both enables set counts as a load
    mem_op(1'b1, 1'b1, 32'h204, 32'h5555_AAAA, 5'd9, 1'b1, 0, 0, 32'h1357_9BDF, 1'b0);
    mem_op(1'b0, 1'b1, 32'h208, 32'h0BAD_CAFE, 5'd2, 1'b0, 0, 0, 32'h0, 1'b0);

    // Misaligned accesses
    misaligned_op(1'b1, 1'b0, 32'h203);
    misaligned_op(1'b0, 1'b1, 32'h102);

    // Timeout boundaries: gnt on the last allowed cycle vs one too late; load never answered
    mem_op(1'b0, 1'b1, 32'h300, 32'h1111_2222, 5'd4, 1'b1, T - 1, 0, 32'h0, 1'b0);
    mem_op(1'b0, 1'b1, 32'h304, 32'h3333_4444, 5'd4, 1'b1, T, 0, 32'h0, 1'b0);
    mem_op(1'b1, 1'b0, 32'h308, 32'h0, 5'd6, 1'b1, 0, T + 4, 32'h7777_8888, 1'b1);

    // Reset while waiting for a load response
    valid_i = 1'b1; dr_en_i = 1'b1; address_i = 32'h400; rd_i = 5'd8; rwr_en_i = 1'b1;
    @(negedge clk_i);
    idle_inputs();
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("rstw_stall", stall_o, 1);
    chk("rstw_req", dmem_req_o, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk_all_zero("rst_in_wait");
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hABCD_0123;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("rstw_late_rvalid", wb_valid_o, 0);
    mem_op(1'b1, 1'b0, 32'h404, 32'h0, 5'd10, 1'b1, 1, 1, 32'h2468_ACE0, 1'b0);

    // Randomized mix
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      a    = {$urandom()} & 32'hFFFF_FFFC;
      if (kind == 0) begin
        alu_op(RW'($urandom()), $urandom(), 1'($urandom()));
      end else if (kind == 1) begin
        a[1:0] = 2'($urandom_range(1, 3));
        ld = 1'($urandom());
        misaligned_op(ld, !ld, a);
      end else begin
        ld = 1'($urandom());
        st = ld ? 1'($urandom()) : 1'b1;
        g  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T + 1) : $urandom_range(0, 3);
        r  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, T) : $urandom_range(0, 4);
        mem_op(ld, st, a, $urandom(), RW'($urandom()), 1'($urandom()), g, r, $urandom(),
               1'($urandom()));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
